sprite_attr_fetch: RTL and testbench
====================================

Name: sprite_attr_fetch

Overview:
- Per-scanline sprite attribute scanner. Reads the sprite attribute RAM through its 32-bit read port: 128 sprites × 8 bytes, 2 words per sprite, little-endian.
- Evaluates each sprite against the current line and streams hit sprites to the sprite line renderer over a valid/ready handshake.
- It is the reader end of the sprite RAM; the CPU/bus side writes the same RAM through the other port.

Parameters:
- NUM_SPRITES, 128, sprites scanned per line (power of 2, ≤128)
- AWID, 8, RAM word address width; word address = {sprite_idx, word_sel}
- MAX_HITS, 64, hits emitted per line before scan stops early

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse: begin scan of line_i (ignored unless idle)
- line_i  in  10  scanline number
- mem_rd_en_o  out  1  RAM read enable (wr_en held 0 by integration)
- mem_addr_o  out  AWID  RAM word address
- mem_rdata_i  in  32  RAM read data (registered RAM output)
- spr_valid_o  out  1  hit attribute valid
- spr_ready_i  in  1  renderer accepts attribute
- spr_idx_o  out  7  sprite index
- spr_addr_o  out  12  word0[11:0], pattern address
- spr_mode_o  out  1  word0[15], 8bpp flag
- spr_x_o  out  10  word0[25:16]
- spr_yoff_o  out  6  line_i − y, row within sprite
- spr_flags_o  out  8  word1[23:16]: collision[7:4], z[3:2], vflip[1], hflip[0]
- spr_size_o  out  8  word1[31:24]: height[7:6], width[5:4], palette offset[3:0]
- busy_o  out  1  scan in progress
- done_o  out  1  one-cycle pulse at end of scan
- overflow_o  out  1  MAX_HITS reached this line; cleared on next accepted start

Behaviour:
- Reset:
  - All outputs 0.
  - FSM to IDLE, sprite index 0, hit count 0.
  - Reset mid-scan aborts immediately; no done_o pulse.
- Read latency LAT:
  - mem_rdata_i is valid LAT cycles after the cycle mem_rd_en_o=1 with a given address.
  - LAT=1 by default; see Optional Feature.
- FSM states:
  - IDLE: on start_i, latch line_i, clear index and hit count, clear overflow_o, busy_o=1, go to RD0.
  - RD0: drive addr {idx,0}, rd_en=1, go to RD1.
  - RD1: drive addr {idx,1}, rd_en=1. Capture word0 when it arrives (LAT after RD0). Go to WAIT.
  - WAIT: stay until word1 arrives (LAT after RD1), capture it, go to EVAL. With LAT=1 WAIT lasts exactly 1 cycle.
  - EVAL: compute the hit (see hit rule). Hit → OUT. Miss → NEXT.
  - OUT: spr_valid_o=1 with all spr_* fields stable until spr_ready_i=1 is sampled high. The transfer cycle increments hit count, then go to NEXT. valid_o drops the cycle after transfer. If valid and ready are both already high on entry, the transfer completes in one cycle.
  - NEXT:
    - idx==NUM_SPRITES−1: go to DONE.
    - hit count==MAX_HITS: set overflow_o, go to DONE.
    - Otherwise idx+1, go to RD0.
  - DONE: done_o=1 for one cycle, busy_o=0, go to IDLE.
- Hit rule:
  - z = word1[19:18], y = word1[9:0], height code h = word1[31:30].
  - Height = 8<<h (8/16/32/64).
  - dy = (line_i − y) mod 1024, a 10-bit wrapping subtract.
  - Hit iff z≠0 and dy < height. spr_yoff_o = dy[5:0].
  - Wrap case: y=1020, h=1 (16 rows), line 3 → dy=7, hit.
- Cycle budget: miss sprite = 4+LAT cycles (RD0, RD1, WAIT, EVAL, NEXT with LAT=1 → 5). No lookahead across sprites.
- start_i while busy: ignored; line latch unchanged.
- No RAM writes ever issued. Only read addresses inside 0..2·NUM_SPRITES−1 are driven.

Optional Feature:
- Macro SPRITE_FETCH_REGMODE_EN.
- Defined: LAT=2, matching the RAM with output register enabled. WAIT holds 2 cycles and word0 capture shifts one cycle later. A miss sprite costs 6 cycles.
- Undefined: LAT=1 as above.
- Handshake and outputs are otherwise identical in both builds.

Test Plan:
- Reset mid-scan: assert rst_i during OUT → next cycle all outputs 0, busy_o=0, no done_o; a following start_i scans normally.
- All z=0, start line 100 → no spr_valid_o; done_o exactly 5·128+1 cycles after start, counted from IDLE (LAT=1).
- Sprite 5 at y=96, h=0 (8 rows), z=3, x=200, pattern addr 0x123; line 100 → single hit: idx 5, spr_x_o=200, spr_yoff_o=4, spr_addr_o=0x123. Line 104 → no hit.
- Wrap: sprite 0 at y=1020, h=1, z=1, line 3 → hit with spr_yoff_o=7. Same sprite, line 12 → miss.
- Backpressure: hit present, spr_ready_i low 10 cycles → valid and fields stable for 10 cycles, single transfer; no RAM reads issued while stalled.
- Overflow: MAX_HITS=4, sprites 0..9 all hitting, ready tied high → 4 transfers (idx 0..3), overflow_o=1, done_o. Next start_i clears overflow_o.

Source files
------------

// File: rtl/sprite_attr_fetch.sv
// Per-scanline sprite attribute scanner: reads two words per sprite, tests the line
// against each sprite and streams hits over valid/ready. Define SPRITE_FETCH_REGMODE_EN for LAT=2.
module sprite_attr_fetch #(
   parameter int NUM_SPRITES = 128,
   parameter int AWID        = 8,
   parameter int MAX_HITS    = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [9:0]      line_i,
   output logic            mem_rd_en_o,
   output logic [AWID-1:0] mem_addr_o,
   input  logic [31:0]     mem_rdata_i,
   output logic            spr_valid_o,
   input  logic            spr_ready_i,
   output logic [6:0]      spr_idx_o,
   output logic [11:0]     spr_addr_o,
   output logic            spr_mode_o,
   output logic [9:0]      spr_x_o,
   output logic [5:0]      spr_yoff_o,
   output logic [7:0]      spr_flags_o,
   output logic [7:0]      spr_size_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            overflow_o
);

`ifdef SPRITE_FETCH_REGMODE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int HW = $clog2(MAX_HITS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
   localparam logic [HW-1:0] HIT_LIM  = HW'(MAX_HITS);

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_WAIT, S_EVAL, S_OUT, S_NEXT, S_DONE
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic [HW-1:0]   r_hits;
   logic [9:0]      r_line;
   logic [31:0]     r_word0;
   logic [31:0]     r_word1;
   logic [LAT:1]    r_vld_pipe;
   logic [LAT:1]    r_sel_pipe;
   logic [LAT:1]    w_vld_nxt;
   logic [LAT:1]    w_sel_nxt;
   logic            w_cap0;
   logic            w_cap1;
   logic [9:0]      w_dy;
   logic [6:0]      w_height;
   logic            w_hit;
   logic            w_unused;

   // Each issued read is tracked with its word select so returning data lands
   // in the right word regardless of latency.
   generate
      if (LAT > 1) begin : g_pipe_n
         assign w_vld_nxt = {r_vld_pipe[LAT-1:1], mem_rd_en_o};
         assign w_sel_nxt = {r_sel_pipe[LAT-1:1], mem_addr_o[0]};
      end else begin : g_pipe_1
         assign w_vld_nxt = mem_rd_en_o;
         assign w_sel_nxt = mem_addr_o[0];
      end
   endgenerate

   assign w_cap0   = r_vld_pipe[LAT] & ~r_sel_pipe[LAT];
   assign w_cap1   = r_vld_pipe[LAT] &  r_sel_pipe[LAT];
   assign w_dy     = r_line - r_word1[9:0];
   assign w_height = 7'd8 << r_word1[31:30];
   assign w_hit    = (r_word1[19:18] != 2'd0) && (w_dy < {3'd0, w_height});
   assign w_unused = ^{r_word0[31:26], r_word0[14:12], r_word1[15:10]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_hits      <= '0;
         r_line      <= '0;
         r_word0     <= '0;
         r_word1     <= '0;
         r_vld_pipe  <= '0;
         r_sel_pipe  <= '0;
         mem_rd_en_o <= 1'b0;
         mem_addr_o  <= '0;
         spr_valid_o <= 1'b0;
         spr_idx_o   <= '0;
         spr_addr_o  <= '0;
         spr_mode_o  <= 1'b0;
         spr_x_o     <= '0;
         spr_yoff_o  <= '0;
         spr_flags_o <= '0;
         spr_size_o  <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         overflow_o  <= 1'b0;
      end else begin
         r_vld_pipe  <= w_vld_nxt;
         r_sel_pipe  <= w_sel_nxt;
         mem_rd_en_o <= 1'b0;
         done_o      <= 1'b0;
         if (w_cap0) r_word0 <= mem_rdata_i;
         if (w_cap1) r_word1 <= mem_rdata_i;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_line      <= line_i;
                  r_idx       <= '0;
                  r_hits      <= '0;
                  overflow_o  <= 1'b0;
                  busy_o      <= 1'b1;
                  mem_rd_en_o <= 1'b1;
                  mem_addr_o  <= '0;
                  r_state     <= S_RD0;
               end
            end
            S_RD0: begin
               mem_rd_en_o <= 1'b1;
               mem_addr_o  <= AWID'({r_idx, 1'b1});
               r_state     <= S_RD1;
            end
            S_RD1: r_state <= S_WAIT;
            S_WAIT: if (w_cap1) r_state <= S_EVAL;
            S_EVAL: begin
               if (w_hit) begin
                  spr_valid_o <= 1'b1;
                  spr_idx_o   <= 7'(r_idx);
                  spr_addr_o  <= r_word0[11:0];
                  spr_mode_o  <= r_word0[15];
                  spr_x_o     <= r_word0[25:16];
                  spr_yoff_o  <= w_dy[5:0];
                  spr_flags_o <= r_word1[23:16];
                  spr_size_o  <= r_word1[31:24];
                  r_state     <= S_OUT;
               end else begin
                  r_state <= S_NEXT;
               end
            end
            S_OUT: begin
               if (spr_ready_i) begin
                  spr_valid_o <= 1'b0;
                  r_hits      <= r_hits + 1'b1;
                  r_state     <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (r_idx == LAST_IDX) begin
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_hits == HIT_LIM) begin
                  overflow_o <= 1'b1;
                  busy_o     <= 1'b0;
                  done_o     <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_idx       <= r_idx + 1'b1;
                  mem_rd_en_o <= 1'b1;
                  mem_addr_o  <= AWID'({r_idx + 1'b1, 1'b0});
                  r_state     <= S_RD0;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Directed + randomized bench for sprite_attr_fetch against a per-line hit-list model.
module tb_sprite_attr_fetch;

`ifdef SPRITE_FETCH_REGMODE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int NSPR = 128;
   localparam int MAXH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [9:0]  line_i;
   logic        mem_rd_en_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_rdata_i;
   logic        spr_valid_o;
   logic        spr_ready_i;
   logic [6:0]  spr_idx_o;
   logic [11:0] spr_addr_o;
   logic        spr_mode_o;
   logic [9:0]  spr_x_o;
   logic [5:0]  spr_yoff_o;
   logic [7:0]  spr_flags_o;
   logic [7:0]  spr_size_o;
   logic        busy_o;
   logic        done_o;
   logic        overflow_o;

   sprite_attr_fetch #(.NUM_SPRITES(NSPR), .AWID(8), .MAX_HITS(MAXH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .line_i(line_i),
      .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
      .spr_valid_o(spr_valid_o), .spr_ready_i(spr_ready_i), .spr_idx_o(spr_idx_o),
      .spr_addr_o(spr_addr_o), .spr_mode_o(spr_mode_o), .spr_x_o(spr_x_o),
      .spr_yoff_o(spr_yoff_o), .spr_flags_o(spr_flags_o), .spr_size_o(spr_size_o),
      .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   // Attribute RAM: registered read port, optional extra output register.
   logic [31:0] ram [0:2*NSPR-1];
   logic [31:0] rq1, rq2;
   always @(posedge clk_i) begin
      if (mem_rd_en_o) rq1 <= ram[mem_addr_o];
      rq2 <= rq1;
   end
   assign mem_rdata_i = (LAT == 2) ? rq2 : rq1;

   int total = 0;
   int bad   = 0;
   logic [51:0] got_q[$];
   logic [51:0] exp_q[$];
   bit   exp_ovf;
   int   n_done = 0, n_rd_stall = 0, n_unstable = 0, nd0;
   bit   rnd_rdy = 0;
   logic p_stall = 1'b0;
   logic [51:0] p_rec;

   function automatic logic [51:0] pk();
      return {spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_yoff_o, spr_flags_o, spr_size_o};
   endfunction

   // Transfer collector and handshake-rule monitor, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (!rst_i && spr_valid_o && spr_ready_i) got_q.push_back(pk());
      if (!rst_i && spr_valid_o && mem_rd_en_o) n_rd_stall <= n_rd_stall + 1;
      if (p_stall && !rst_i && !(spr_valid_o && pk() == p_rec)) n_unstable <= n_unstable + 1;
      if (done_o) n_done <= n_done + 1;
      p_stall <= spr_valid_o && !spr_ready_i && !rst_i;
      p_rec   <= pk();
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected hit list for a line, straight from the sprite table.
   task automatic model(input int line);
      exp_q.delete();
      exp_ovf = 0;
      for (int s = 0; s < NSPR; s++) begin
         logic [31:0] w0, w1;
         int y, h, dy;
         w0 = ram[2*s];
         w1 = ram[2*s+1];
         y  = int'(w1[9:0]);
         h  = int'(w1[31:30]);
         dy = (line - y + 1024) % 1024;
         if (w1[19:18] != 2'b00 && dy < (8 << h)) begin
            exp_q.push_back({7'(s), w0[11:0], w0[15], w0[25:16], 6'(dy), w1[23:16], w1[31:24]});
            if (exp_q.size() == MAXH) begin
               exp_ovf = (s != NSPR - 1);
               break;
            end
         end
      end
   endtask

   task automatic clear_ram();
      for (int i = 0; i < 2*NSPR; i++) ram[i] = 32'h0;
   endtask

   task automatic start_scan(input int line);
      got_q.delete();
      model(line);
      nd0 = n_done;
      line_i  = 10'(line);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done_o && cyc < 6000) begin
         @(posedge clk_i); #1;
         cyc++;
         if (rnd_rdy) spr_ready_i = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic post_done(input string tag);
      check({tag, "_done_seen"}, done_o, 1);
      @(posedge clk_i); #1;
      check({tag, "_done_pulse"}, done_o, 0);
      check({tag, "_busy_off"}, busy_o, 0);
   endtask

   task automatic check_result(input string tag);
      check({tag, "_nhits"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_hit"}, got_q[i], exp_q[i]);
      check({tag, "_ovf"}, overflow_o, exp_ovf);
      check({tag, "_ndone"}, n_done - nd0, 1);
   endtask

   task automatic put_s5(input int y);
      ram[10] = (32'd200 << 16) | 32'h123;
      ram[11] = (32'd3 << 18) | 32'(y);
   endtask

   initial begin
      int cyc, k;
      logic [51:0] r, snap;
      rst_i = 1'b1; start_i = 1'b0; line_i = '0; spr_ready_i = 1'b1;
      clear_ram();
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_outs", {mem_rd_en_o, mem_addr_o, spr_valid_o, pk()}, 0);
      check("reset_status", {busy_o, done_o, overflow_o}, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // All sprites invisible (z=0): timing of an all-miss line.
      for (int s = 0; s < NSPR; s++) begin
         ram[2*s]   = $urandom;
         ram[2*s+1] = $urandom & ~(32'h3 << 18);
      end
      start_scan(100);
      check("miss_busy", busy_o, 1);
      wait_done(cyc);
      check("miss_done_cyc", cyc + 1, NSPR*(4+LAT) + 1);
      post_done("miss");
      check_result("miss");

      // Single sprite hit; a start mid-scan must not disturb the latched line.
      clear_ram();
      put_s5(96);
      start_scan(100);
      repeat (20) @(posedge clk_i);
      #1;
      line_i = 10'd104; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_done(cyc);
      post_done("s5");
      check_result("s5");
      check("s5_count", got_q.size(), 1);
      if (got_q.size() > 0) begin
         r = got_q[0];
         check("s5_idx",  r[51:45], 5);
         check("s5_addr", r[44:33], 12'h123);
         check("s5_x",    r[31:22], 200);
         check("s5_yoff", r[21:16], 4);
      end
      start_scan(104);
      wait_done(cyc);
      post_done("s5_104");
      check_result("s5_104");
      check("s5_104_none", got_q.size(), 0);

      // Vertical wrap around line 1023.
      clear_ram();
      ram[0] = 32'h0;
      ram[1] = (32'd1 << 30) | (32'd1 << 18) | 32'd1020;
      start_scan(3);
      wait_done(cyc);
      post_done("wrap");
      check_result("wrap");
      if (got_q.size() > 0) begin
         r = got_q[0];
         check("wrap_yoff", r[21:16], 7);
      end
      start_scan(12);
      wait_done(cyc);
      post_done("wrap12");
      check("wrap12_none", got_q.size(), 0);

      // Backpressure: hold ready low while a hit is presented.
      clear_ram();
      put_s5(96);
      spr_ready_i = 1'b0;
      start_scan(100);
      k = 0;
      while (!spr_valid_o && k < 400) begin @(posedge clk_i); #1; k++; end
      check("bp_valid_seen", spr_valid_o, 1);
      snap = pk();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         check("bp_valid", spr_valid_o, 1);
         check("bp_fields", pk(), snap);
         check("bp_no_rd", mem_rd_en_o, 0);
      end
      spr_ready_i = 1'b1;
      wait_done(cyc);
      post_done("bp");
      check_result("bp");

      // Hit limit reached early.
      clear_ram();
      for (int s = 0; s < 10; s++) begin
         ram[2*s]   = 32'(s);
         ram[2*s+1] = (32'd1 << 18) | 32'd96;
      end
      start_scan(100);
      wait_done(cyc);
      post_done("ovf");
      check_result("ovf");
      check("ovf_set", overflow_o, 1);
      start_scan(100);
      check("ovf_cleared", overflow_o, 0);
      wait_done(cyc);
      post_done("ovf2");
      check_result("ovf2");

      // Reset while a hit is stalled in the output stage.
      clear_ram();
      put_s5(96);
      spr_ready_i = 1'b0;
      start_scan(100);
      k = 0;
      while (!spr_valid_o && k < 400) begin @(posedge clk_i); #1; k++; end
      check("rst_valid_seen", spr_valid_o, 1);
      k = n_done;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("rst_mid_outs", {mem_rd_en_o, mem_addr_o, spr_valid_o, pk()}, 0);
      check("rst_mid_status", {busy_o, done_o, overflow_o}, 0);
      rst_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_no_done", n_done, k);
      spr_ready_i = 1'b1;
      start_scan(100);
      wait_done(cyc);
      post_done("after_rst");
      check_result("after_rst");

      // Randomized sprite tables, lines and backpressure.
      for (int it = 0; it < 8; it++) begin
         int ln;
         ln = $urandom_range(0, 1023);
         for (int s = 0; s < NSPR; s++) begin
            logic [31:0] w1;
            w1 = $urandom;
            if ($urandom_range(0, 99) < it*2) w1[9:0] = 10'(ln - int'($urandom_range(0, 70)));
            if ($urandom_range(0, 1) == 0) w1[19:18] = 2'b00;
            ram[2*s]   = $urandom;
            ram[2*s+1] = w1;
         end
         rnd_rdy = 1;
         start_scan(ln);
         wait_done(cyc);
         rnd_rdy = 0;
         spr_ready_i = 1'b1;
         post_done("rand");
         check_result("rand");
      end

      check("no_rd_while_valid", n_rd_stall, 0);
      check("valid_stable", n_unstable, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
